// File: rtl/md_unit_scheduler_pkg.sv
// Shared types and default latencies for the multiply/divide unit scheduler.
// Op encoding matches the EX-stage MdOpE field; bit 1 distinguishes divides.
package mips_md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_DIVZ = 2'b11
  } md_state_t;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;
  localparam int DEF_CNT_W   = 6;

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_unit_scheduler_if.sv
// Signal bundle between EX/ID/hazard logic and the MDU scheduler.
// master = pipeline side driving requests, slave = scheduler.
interface md_unit_scheduler_if;

  logic       MdStartE;
  logic [1:0] MdOpE;
  logic       MdDivZeroE;
  logic       MdUseD;

  logic       MdBusy;
  logic       MdStallD;
  logic       MdInit;
  logic       MdStep;
  logic [1:0] MdOp;
  logic       MdHiLoWE;
  logic       MdDivZero;
  logic       MdErr;

  modport master (
    output MdStartE, MdOpE, MdDivZeroE, MdUseD,
    input  MdBusy, MdStallD, MdInit, MdStep, MdOp, MdHiLoWE, MdDivZero, MdErr
  );

  modport slave (
    input  MdStartE, MdOpE, MdDivZeroE, MdUseD,
    output MdBusy, MdStallD, MdInit, MdStep, MdOp, MdHiLoWE, MdDivZero, MdErr
  );

endinterface

// File: rtl/md_unit_scheduler_lat_counter.sv
// Load/decrement latency counter for the MDU RUN phase.
// Saturates at zero so a late decrement can never wrap into a long stall.
module md_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_unit_scheduler.sv
// Sequencer for the iterative multiply/divide unit: issues init/step/HI-LO write
// and the decode-stage stall request.
//   state  | meaning
//   S_IDLE | no op in flight, accepts MdStartE
//   S_RUN  | datapath iterating, one MdStep per cycle
//   S_DONE | result ready, HI/LO written this cycle
//   S_DIVZ | divide by zero, flag only, HI/LO untouched
module md_unit_scheduler
  import mips_md_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  md_unit_scheduler_if.slave md
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_t state, stateNext;
  md_op_t    opReg;
  logic      errReg;

  logic             cntLoad;
  logic             cntDec;
  logic             cntZero;
  logic [CNT_W-1:0] cntLoadVal;
  logic             startReq;
  logic             opEIsDiv;
  logic             divZeroStart;
  logic             initPulse;
  logic             busy;

  assign startReq     = md.MdStartE && !rst;
  assign opEIsDiv     = isDivOp(md.MdOpE);
  assign divZeroStart = opEIsDiv && md.MdDivZeroE;
  assign cntLoadVal   = opEIsDiv ? DIV_LOAD : MUL_LOAD;

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .dec     (cntDec),
    .zero    (cntZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    initPulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (startReq) begin
          initPulse = 1'b1;
          if (divZeroStart) begin
            stateNext = S_DIVZ;
          end else begin
            cntLoad   = 1'b1;
            stateNext = S_RUN;
          end
        end
      end
      S_RUN: begin
        // The step in the cnt==0 cycle is the last of LAT steps.
        cntDec = !cntZero;
        if (cntZero) begin
          stateNext = S_DONE;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      S_DIVZ:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Op latch and sticky protocol-violation flag; a start while busy is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg  <= MD_MULT;
      errReg <= 1'b0;
    end else begin
      if (initPulse) begin
        opReg <= md_op_t'(md.MdOpE);
      end
      if (md.MdStartE && (state != S_IDLE)) begin
        errReg <= 1'b1;
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign md.MdBusy    = busy;
  assign md.MdStep    = (state == S_RUN);
  assign md.MdHiLoWE  = (state == S_DONE);
  assign md.MdDivZero = (state == S_DIVZ);
  assign md.MdInit    = initPulse;
  assign md.MdOp      = opReg;
  assign md.MdErr     = errReg;
  // Stall covers the issue cycle too, so an MFHI/MFLO never slips past a fresh start.
  assign md.MdStallD  = md.MdUseD && (busy || md.MdStartE);

endmodule

// File: tb/tb_md_unit_scheduler.sv
// Scoreboard bench for md_unit_scheduler: interval-based reference model for
// per-cycle outputs, completion queue checked by an independent monitor.
module tb_md_unit_scheduler;
  import mips_md_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  typedef struct {
    int         due;
    bit         dz;
    logic [1:0] op;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_scheduler_if mdIf ();

  md_unit_scheduler #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .md  (mdIf)
  );

  exp_t sbq[$];
  exp_t monE;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  bit         modelValid = 0;
  bit         mAct       = 0;
  int         tS         = 0;
  bit         tDz        = 0;
  int         tLat       = 0;
  bit         mErr       = 0;
  logic [1:0] mOp        = 2'b00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, expv);
    end
  endtask

  // Op started at tS occupies tS+1 .. tS+LAT+1 (or just tS+1 for a divide by zero).
  function automatic bit busyAt(input int c);
    return mAct && (c >= tS + 1) && (c <= tS + (tDz ? 1 : tLat + 1));
  endfunction

  function automatic bit stepAt(input int c);
    return mAct && !tDz && (c >= tS + 1) && (c <= tS + tLat);
  endfunction

  function automatic bit hiloAt(input int c);
    return mAct && !tDz && (c == tS + tLat + 1);
  endfunction

  function automatic bit dzAt(input int c);
    return mAct && tDz && (c == tS + 1);
  endfunction

  task automatic cycle(input logic st, input logic [1:0] op, input logic dz,
                       input logic use_, input logic r);
    bit b;
    mdIf.MdStartE   = st;
    mdIf.MdOpE      = op;
    mdIf.MdDivZeroE = dz;
    mdIf.MdUseD     = use_;
    rst             = r;
    @(negedge clk);
    if (modelValid) begin
      b = busyAt(cyc);
      chk("MdBusy",    {31'b0, mdIf.MdBusy},    {31'b0, b});
      chk("MdStep",    {31'b0, mdIf.MdStep},    {31'b0, stepAt(cyc)});
      chk("MdHiLoWE",  {31'b0, mdIf.MdHiLoWE},  {31'b0, hiloAt(cyc)});
      chk("MdDivZero", {31'b0, mdIf.MdDivZero}, {31'b0, dzAt(cyc)});
      chk("MdInit",    {31'b0, mdIf.MdInit},    {31'b0, (st && !r && !b)});
      chk("MdStallD",  {31'b0, mdIf.MdStallD},  {31'b0, (use_ && (b || st))});
      chk("MdErr",     {31'b0, mdIf.MdErr},     {31'b0, mErr});
      chk("MdOp",      {30'b0, mdIf.MdOp},      {30'b0, mOp});
    end
    @(posedge clk);
    if (r) begin
      mAct       = 0;
      mErr       = 0;
      mOp        = 2'b00;
      sbq.delete();
      modelValid = 1;
    end else if (modelValid) begin
      b = busyAt(cyc);
      if (st && b) mErr = 1;
      if (st && !b) begin
        mAct = 1;
        tS   = cyc;
        tDz  = op[1] && dz;
        tLat = op[1] ? DIV_LAT : MUL_LAT;
        mOp  = op;
        sbq.push_back('{due: cyc + (tDz ? 1 : tLat + 1), dz: tDz, op: op});
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (modelValid && (mdIf.MdHiLoWE === 1'b1 || mdIf.MdDivZero === 1'b1)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected cycle=%0d hilo=%0b divzero=%0b expected=none",
                 cyc, mdIf.MdHiLoWE, mdIf.MdDivZero);
      end else begin
        monE = sbq.pop_front();
        chk("sb_due",  cyc, monE.due);
        chk("sb_kind", {31'b0, mdIf.MdDivZero}, {31'b0, monE.dz});
        chk("sb_op",   {30'b0, mdIf.MdOp}, {30'b0, monE.op});
      end
    end
  end

  initial begin
    mdIf.MdStartE   = 1'b0;
    mdIf.MdOpE      = 2'b00;
    mdIf.MdDivZeroE = 1'b0;
    mdIf.MdUseD     = 1'b0;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2);

    // MULT latency
    cycle(1'b1, MD_MULT, 1'b0, 1'b0, 1'b0);
    idle(7);
    // DIVU full latency, op held
    cycle(1'b1, MD_DIVU, 1'b0, 1'b0, 1'b0);
    idle(36);
    // DIV by zero
    cycle(1'b1, MD_DIV, 1'b1, 1'b0, 1'b0);
    idle(3);
    // MFLO waiting in ID across the whole op
    cycle(1'b1, MD_MULT, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);
    // start while busy: ignored, MdErr sticky until reset
    cycle(1'b1, MD_MULTU, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, MD_DIV, 1'b0, 1'b1, 1'b0);
    idle(8);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2);
    // reset at RUN cycle 2
    cycle(1'b1, MD_MULT, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 149) == 0));
    end
    idle(40);
    chk("sb_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
